// File: rtl/frame_unpacker_pkg.sv
// Shared receiver definitions: frame layout, sync/CRC constants and unpacker state encodings.
package frame_unpacker_pkg;

  localparam int FRAME_W       = 71;
  localparam int SYNC_HI       = 70;
  localparam int SYNC_LO       = 63;
  localparam int SEQ_HI        = 62;
  localparam int SEQ_LO        = 55;
  localparam int PAYLOAD_HI    = 54;
  localparam int PAYLOAD_LO    = 7;
  localparam int CRC_HI        = 6;
  localparam int CRC_LO        = 0;
  localparam int PAYLOAD_BYTES = 6;

  localparam logic [7:0] SYNC_WORD = 8'hA5;
  localparam logic [6:0] CRC_POLY  = 7'h09;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_VERDICT = 2'd2;
  localparam logic [1:0] ST_EMIT    = 2'd3;

  // Payload byte 0 sits at the top of the payload field.
  function automatic logic [7:0] payload_byte(input logic [FRAME_W-1:0] frame,
                                              input logic [2:0] idx);
    return frame[PAYLOAD_HI - 8 * int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/frame_unpacker_if.sv
// Payload byte stream (valid/ready) from the unpacker to display/storage logic.
interface frame_unpacker_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic [7:0] seq_out;

  modport master (output byte_out, byte_valid, byte_last, seq_out, input byte_ready);
  modport slave  (input byte_out, byte_valid, byte_last, seq_out, output byte_ready);
endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC-7, MSB first; shared with the transmitter-side frame builder.
module crc7_serial
  import frame_unpacker_pkg::*;
#(
  parameter logic [6:0] POLY = CRC_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
    end
  end

endmodule

// File: rtl/frame_unpacker.sv
// Latches deserialized frames, checks sync and CRC-7, tracks sequence continuity and streams
// the payload bytes of good frames; saturating debug counters.
module frame_unpacker
  import frame_unpacker_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FRAME_W-1:0]   frame_in,
  input  logic                 frame_strobe,
  frame_unpacker_if.master     bs,
  output logic                 seq_gap,
  output logic                 busy,
  output logic [CNT_W-1:0]     frames_ok,
  output logic [CNT_W-1:0]     crc_err_cnt,
  output logic [CNT_W-1:0]     sync_err_cnt,
  output logic [CNT_W-1:0]     overrun_cnt
);

  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [5:0]         bit_idx_q;
  logic [2:0]         byte_idx_q;
  logic [7:0]         expected_seq_q;
  logic               first_frame_q;
  logic [6:0]         crc;

  logic       sync_ok, start, crc_ok, emit, accept;
  logic [7:0] seq;

  assign sync_ok = frame_in[SYNC_HI:SYNC_LO] == SYNC_WORD;
  assign start   = (state_q == ST_IDLE) && frame_strobe && sync_ok;
  assign crc_ok  = crc == frame_q[CRC_HI:CRC_LO];
  assign seq     = frame_q[SEQ_HI:SEQ_LO];
  assign emit    = state_q == ST_EMIT;
  assign accept  = emit && bs.byte_ready;

  crc7_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (state_q == ST_CHECK),
    .bit_in (frame_q[bit_idx_q]),
    .crc    (crc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_CHECK;
      ST_CHECK:   if (bit_idx_q == 6'(PAYLOAD_LO)) state_d = ST_VERDICT;
      ST_VERDICT: state_d = crc_ok ? ST_EMIT : ST_IDLE;
      ST_EMIT:    if (accept && byte_idx_q == 3'(PAYLOAD_BYTES - 1)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      bit_idx_q      <= '0;
      byte_idx_q     <= '0;
      expected_seq_q <= '0;
      first_frame_q  <= 1'b1;
      frames_ok      <= '0;
      crc_err_cnt    <= '0;
      sync_err_cnt   <= '0;
      overrun_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        frame_q   <= frame_in;
        bit_idx_q <= 6'(SEQ_HI);
      end
      if (state_q == ST_CHECK) bit_idx_q <= bit_idx_q - 6'd1;
      if ((state_q == ST_IDLE) && frame_strobe && !sync_ok && !(&sync_err_cnt)) begin
        sync_err_cnt <= sync_err_cnt + CNT_W'(1);
      end
      // Strobes outside IDLE are dropped; the in-flight frame continues untouched.
      if ((state_q != ST_IDLE) && frame_strobe && !(&overrun_cnt)) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
      if (state_q == ST_VERDICT) begin
        if (!crc_ok) begin
          if (!(&crc_err_cnt)) crc_err_cnt <= crc_err_cnt + CNT_W'(1);
        end else begin
          if (!(&frames_ok)) frames_ok <= frames_ok + CNT_W'(1);
          expected_seq_q <= seq + 8'd1;
          first_frame_q  <= 1'b0;
          byte_idx_q     <= '0;
        end
      end
      if (accept) byte_idx_q <= byte_idx_q + 3'd1;
    end
  end

  assign busy          = state_q != ST_IDLE;
  assign seq_gap       = (state_q == ST_VERDICT) && crc_ok && !first_frame_q &&
                         (seq != expected_seq_q);
  assign bs.byte_valid = emit;
  assign bs.byte_out   = emit ? payload_byte(frame_q, byte_idx_q) : 8'h00;
  assign bs.byte_last  = emit && (byte_idx_q == 3'(PAYLOAD_BYTES - 1));
  assign bs.seq_out    = emit ? seq : 8'h00;

endmodule

// File: tb/tb_frame_unpacker.sv
// Directed self-checking bench for frame_unpacker.
module tb_frame_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [70:0] frame_in = '0;
  logic        frame_strobe = 1'b0;
  logic        seq_gap, busy;
  logic [7:0]  frames_ok, crc_err_cnt, sync_err_cnt, overrun_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] bq[$];
  logic       lq[$];
  logic [7:0] sq[$];
  int         gap_cnt = 0;
  int         busy_seen = 0;

  frame_unpacker_if bs_if ();

  frame_unpacker #(
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_in     (frame_in),
    .frame_strobe (frame_strobe),
    .bs           (bs_if),
    .seq_gap      (seq_gap),
    .busy         (busy),
    .frames_ok    (frames_ok),
    .crc_err_cnt  (crc_err_cnt),
    .sync_err_cnt (sync_err_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Record accepted bytes and pulses on the falling edge, ahead of the accepting rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bs_if.byte_valid && bs_if.byte_ready) begin
        bq.push_back(bs_if.byte_out);
        lq.push_back(bs_if.byte_last);
        sq.push_back(bs_if.seq_out);
      end
      if (seq_gap) gap_cnt++;
      if (busy) busy_seen++;
    end
  end

  // Reference CRC by polynomial long division of msg * x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc_model(input logic [55:0] msg);
    logic [62:0] r;
    r = {msg, 7'b0};
    for (int i = 62; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [70:0] mk_frame(input logic [7:0] seq, input logic [47:0] pl);
    return {8'hA5, seq, pl, crc_model({seq, pl})};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    frame_strobe = 1'b0;
    bs_if.byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bq.delete(); lq.delete(); sq.delete();
    gap_cnt = 0;
    busy_seen = 0;
  endtask

  // Strobe is sampled at the rising edge this task waits on (E0).
  task automatic pulse(input logic [70:0] f);
    frame_in = f;
    frame_strobe = 1'b1;
    @(posedge clk);
    #1 frame_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: timeout, busy=%0b required 0", name, busy);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bs_if.byte_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!bs_if.byte_valid) begin
      errors++;
      $display("FAIL %s: byte_valid never rose", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bs_if.byte_valid, bs_if.byte_last, busy, seq_gap} !== 4'b0000 ||
        bs_if.byte_out !== 8'h00 || bs_if.seq_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b gap=%0b byte=%h seq=%h required 0",
               bs_if.byte_valid, bs_if.byte_last, busy, seq_gap, bs_if.byte_out, bs_if.seq_out);
    end
    checks++;
    if ({frames_ok, crc_err_cnt, sync_err_cnt, overrun_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: %h %h %h %h required 0",
               frames_ok, crc_err_cnt, sync_err_cnt, overrun_cnt);
    end
  endtask

  task automatic test_zero_frame();
    logic ok;
    do_reset();
    pulse({8'hA5, 56'b0, 7'h00});
    repeat (56) @(posedge clk);
    #1 checks++;
    if (bs_if.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: byte_valid=%0b after E56 required 0", bs_if.byte_valid);
    end
    @(posedge clk);
    #1 checks++;
    if (bs_if.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_e57: byte_valid=%0b after E57 required 1", bs_if.byte_valid);
    end
    wait_idle("zero_idle");
    ok = (bq.size() == 6);
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i] !== 8'h00 || lq[i] !== (i == 5)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_bytes: got %0d bytes %p last %p required six 00 with last on 6th",
               bq.size(), bq, lq);
    end
    checks++;
    if (frames_ok !== 8'd1) begin
      errors++;
      $display("FAIL zero_frames_ok: got %0d required 1", frames_ok);
    end
  endtask

  task automatic test_crc();
    do_reset();
    pulse({8'hA5, 8'h00, 47'b0, 1'b1, 7'h09});
    wait_idle("crc_good_idle");
    checks++;
    if (bq.size() != 6 || bq[5] !== 8'h01 || frames_ok !== 8'd1 || crc_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL crc_good: nbytes=%0d frames_ok=%0d crc_err=%0d required 6 bytes, byte5=01, 1, 0",
               bq.size(), frames_ok, crc_err_cnt);
    end
    bq.delete();
    pulse({8'hA5, 8'h00, 47'b0, 1'b1, 7'h08});
    wait_idle("crc_bad_idle");
    checks++;
    if (bq.size() != 0 || crc_err_cnt !== 8'd1 || frames_ok !== 8'd1) begin
      errors++;
      $display("FAIL crc_bad: nbytes=%0d crc_err=%0d frames_ok=%0d required 0, 1, 1",
               bq.size(), crc_err_cnt, frames_ok);
    end
  endtask

  task automatic test_sync();
    do_reset();
    pulse({8'hA4, 56'b0, 7'h00});
    repeat (70) @(posedge clk);
    #1 checks++;
    if (busy_seen != 0 || bq.size() != 0 || sync_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sync_err: busy_cycles=%0d nbytes=%0d sync_err=%0d required 0, 0, 1",
               busy_seen, bq.size(), sync_err_cnt);
    end
  endtask

  task automatic test_seq_gap();
    logic ok;
    do_reset();
    pulse(mk_frame(8'd0, 48'h0102_0304_0506));
    wait_idle("seq0");
    bq.delete(); sq.delete();
    pulse(mk_frame(8'd1, 48'h1122_3344_5566));
    wait_idle("seq1");
    ok = (bq.size() == 6);
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i] !== 8'(8'h11 * (i + 1)) || sq[i] !== 8'd1) ok = 1'b0;
    end
    checks++;
    if (!ok || gap_cnt != 0) begin
      errors++;
      $display("FAIL seq1_bytes: bytes %p seq %p gaps %0d required 11..66, seq 1, 0 gaps",
               bq, sq, gap_cnt);
    end
    pulse(mk_frame(8'd3, 48'hA0A1_A2A3_A4A5));
    wait_idle("seq3");
    checks++;
    if (gap_cnt != 1 || frames_ok !== 8'd3) begin
      errors++;
      $display("FAIL seq3_gap: gaps=%0d frames_ok=%0d required 1, 3", gap_cnt, frames_ok);
    end
    do_reset();
    pulse(mk_frame(8'd255, 48'h0));
    wait_idle("seq255");
    pulse(mk_frame(8'd0, 48'h0));
    wait_idle("seq_wrap");
    checks++;
    if (gap_cnt != 0 || frames_ok !== 8'd2) begin
      errors++;
      $display("FAIL seq_wrap: gaps=%0d frames_ok=%0d required 0, 2", gap_cnt, frames_ok);
    end
  endtask

  task automatic test_stall_overrun();
    logic [7:0] exp_b[6] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
    int bad;
    logic ok;
    do_reset();
    bs_if.byte_ready = 1'b0;
    pulse(mk_frame(8'd7, 48'hDEAD_BEEF_CAFE));
    repeat (10) @(posedge clk);
    #1 pulse(mk_frame(8'd9, 48'h1234_5678_9ABC));
    wait_valid("stall_valid");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bs_if.byte_valid !== 1'b1 || bs_if.byte_out !== 8'hDE || bs_if.byte_last !== 1'b0 ||
          bs_if.seq_out !== 8'd7) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable cycles required 0", bad);
    end
    bs_if.byte_ready = 1'b1;
    wait_idle("stall_idle");
    ok = (bq.size() == 6);
    for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i] || sq[i] !== 8'd7) ok = 1'b0;
    checks++;
    if (!ok || overrun_cnt !== 8'd1 || frames_ok !== 8'd1) begin
      errors++;
      $display("FAIL overrun: bytes %p overrun=%0d frames_ok=%0d required DE AD BE EF CA FE, 1, 1",
               bq, overrun_cnt, frames_ok);
    end
  endtask

  task automatic test_reset_mid_emit();
    do_reset();
    bs_if.byte_ready = 1'b0;
    pulse(mk_frame(8'd4, 48'h5555_AAAA_5555));
    frame_in = {8'h00, 63'b0};
    frame_strobe = 1'b1;
    @(posedge clk);
    #1 frame_strobe = 1'b0;
    wait_valid("mid_valid");
    reset = 1'b1;
    @(posedge clk);
    #1 checks++;
    if (bs_if.byte_valid !== 1'b0 || busy !== 1'b0 ||
        {frames_ok, crc_err_cnt, sync_err_cnt, overrun_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_emit: valid=%0b busy=%0b counters %h %h %h %h required all 0",
               bs_if.byte_valid, busy, frames_ok, crc_err_cnt, sync_err_cnt, overrun_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    frame_in = {8'h5A, 63'b0};
    frame_strobe = 1'b1;
    repeat (300) @(posedge clk);
    #1 frame_strobe = 1'b0;
    checks++;
    if (sync_err_cnt !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL sync_saturate: got %h busy=%0b required FF, 0", sync_err_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(mk_frame(8'd10, 48'h0F0E_0D0C_0B0A));
    wait_idle("b2b_first");
    pulse(mk_frame(8'd11, 48'hFFEE_DDCC_BBAA));
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%0b required 1", busy);
    end
    wait_idle("b2b_second");
    checks++;
    if (frames_ok !== 8'd2 || bq.size() != 12 || bq[11] !== 8'hAA || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_frames: frames_ok=%0d nbytes=%0d overrun=%0d required 2, 12, 0",
               frames_ok, bq.size(), overrun_cnt);
    end
  endtask

  initial begin
    bs_if.byte_ready = 1'b1;
    test_reset();
    test_zero_frame();
    test_crc();
    test_sync();
    test_seq_gap();
    test_stall_overrun();
    test_reset_mid_emit();
    test_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
